// File: rtl/aoc5_pkg.sv
// Shared types for the aoc5 sort/merge pipeline (run_sorter, merge_phase).
// Bank address width comes from `BANK_ADDR_WIDTH (defaults to 10 here).
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 10
`endif

package aoc5_pkg;

    // Element carried through the sorter; ordered as one unsigned vector.
    typedef struct packed {
        logic [15:0] key;
        logic [15:0] val;
    } tuple_pair_t;

    localparam int          RUN_LEN_DEF = 16;
    localparam tuple_pair_t TUPLE_ONES  = '1;

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_DONE} sort_state_t;

    // Unsigned full-vector less-than for tuple_pair_t.
    function automatic logic pair_lt(input tuple_pair_t a, input tuple_pair_t b);
        logic [$bits(tuple_pair_t)-1:0] av;
        logic [$bits(tuple_pair_t)-1:0] bv;
        av = a;
        bv = b;
        return av < bv;
    endfunction

endpackage

// File: rtl/insert_cell.sv
// One slot of the insertion array: on insert it either shifts in its
// lower neighbour, captures the new element, or holds.
module insert_cell
    import aoc5_pkg::*;
#(
    parameter bit IS_FIRST = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        insert,
    input  tuple_pair_t new_data,
    input  tuple_pair_t prev_data,
    output tuple_pair_t slot_q
);

    // Equal keys fall through to "hold" on this slot, so new equals land after old ones.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            slot_q <= TUPLE_ONES;
        end else if (insert) begin
            if (!IS_FIRST && pair_lt(new_data, prev_data))
                slot_q <= prev_data;
            else if (pair_lt(new_data, slot_q))
                slot_q <= new_data;
        end
    end

endmodule

// File: rtl/run_sorter.sv
// Insertion sorter producing RUN_LEN-element ascending runs, written out as
// even/odd pairs for a two-bank store. Optional output ordering check is
// enabled with `define RUN_SORTER_CHECK_EN.
module run_sorter
    import aoc5_pkg::*;
#(
    parameter int RUN_LEN = RUN_LEN_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  tuple_pair_t                 in_data,
    input  logic                        in_last,
    output tuple_pair_t                 even_data_out,
    output tuple_pair_t                 odd_data_out,
    output logic [`BANK_ADDR_WIDTH-1:0] write_addr_out,
    output logic                        write_en_out,
    output logic [15:0]                 runs_out,
    output logic                        done_out,
    output logic                        sort_err_out
);

    localparam int HALF = RUN_LEN / 2;
    localparam int KW   = $clog2(HALF);
    localparam int CW   = $clog2(RUN_LEN);
    localparam int AW   = `BANK_ADDR_WIDTH;

    sort_state_t   state;
    logic [KW-1:0] drain_k;
    logic [CW-1:0] fill_cnt;
    logic          ended_last;
    logic [AW-1:0] run_base;

    // chain[0] is a sentinel below slot 0; chain[i+1] is slot i.
    tuple_pair_t chain [RUN_LEN+1];

    logic accept;
    logic drain_end;

    assign in_ready  = (state == S_FILL);
    assign accept    = in_valid && in_ready;
    assign drain_end = (state == S_DRAIN) && (drain_k == KW'(HALF - 1));
    assign chain[0]  = TUPLE_ONES;

    for (genvar g = 0; g < RUN_LEN; g++) begin : g_cell
        insert_cell #(.IS_FIRST(g == 0)) u_cell (
            .clock     (clock),
            .reset     (reset),
            .clear     (drain_end),
            .insert    (accept),
            .new_data  (in_data),
            .prev_data (chain[g]),
            .slot_q    (chain[g+1])
        );
    end

    // Control FSM plus registered write port toward the run banks.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_FILL;
            drain_k        <= '0;
            fill_cnt       <= '0;
            ended_last     <= 1'b0;
            run_base       <= '0;
            write_addr_out <= '0;
            write_en_out   <= 1'b0;
            even_data_out  <= '0;
            odd_data_out   <= '0;
            runs_out       <= '0;
            done_out       <= 1'b0;
        end else begin
            write_en_out <= 1'b0;
            done_out     <= (state == S_DONE);
            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (in_last || fill_cnt == CW'(RUN_LEN - 1)) begin
                            state      <= S_DRAIN;
                            ended_last <= in_last;
                            fill_cnt   <= '0;
                            drain_k    <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    write_en_out   <= 1'b1;
                    even_data_out  <= chain[2*int'(drain_k) + 1];
                    odd_data_out   <= chain[2*int'(drain_k) + 2];
                    write_addr_out <= run_base + AW'({drain_k, 1'b0});
                    drain_k        <= drain_k + KW'(1);
                    if (drain_end) begin
                        drain_k  <= '0;
                        run_base <= run_base + AW'(RUN_LEN);
                        if (runs_out != 16'hFFFF)
                            runs_out <= runs_out + 16'd1;
                        state <= ended_last ? S_DONE : S_FILL;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RUN_SORTER_CHECK_EN
    logic        wr_first;
    tuple_pair_t prev_odd;

    // Tag the first write of each run so the cross-pair check restarts there.
    always_ff @(posedge clock) begin
        if (reset)
            wr_first <= 1'b0;
        else
            wr_first <= (state == S_DRAIN) && (drain_k == '0);
    end

    // Sticky check: pairs ordered internally and against the previous pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            sort_err_out <= 1'b0;
            prev_odd     <= '0;
        end else if (write_en_out) begin
            prev_odd <= odd_data_out;
            if (pair_lt(odd_data_out, even_data_out))
                sort_err_out <= 1'b1;
            if (!wr_first && pair_lt(even_data_out, prev_odd))
                sort_err_out <= 1'b1;
        end
    end
`else
    assign sort_err_out = 1'b0;
`endif

endmodule

// File: doc/run_sorter.md
RUN_SORTER -- requirements
Module: run_sorter

Interface
REQ-001 SHALL have parameter RUN_LEN, default 16, elements per sorted run (even, >=4).
REQ-002 SHALL have clock  input  1  rising-edge clock.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have in_valid  input  1  upstream element valid.
REQ-005 SHALL have in_ready  output  1  element accepted when in_valid && in_ready.
REQ-006 SHALL have in_data  input  tuple_pair_t  element, compared as unsigned full vector.
REQ-007 SHALL have in_last  input  1  qualifies final element of the stream.
REQ-008 SHALL have even_data_out / odd_data_out  output  tuple_pair_t  elements 2k / 2k+1 of the run.
REQ-009 SHALL have write_addr_out  output  `BANK_ADDR_WIDTH  element index of even_data_out.
REQ-010 SHALL have write_en_out  output  1  bank write strobe.
REQ-011 SHALL have runs_out  output  16  completed runs written.
REQ-012 SHALL have done_out  output  1  all runs written, merge may start.
REQ-013 SHALL have sort_err_out  output  1  sticky ordering-check failure.

Function
REQ-014 SHALL hold a RUN_LEN-entry register array kept ascending; empty slots hold all-ones.
REQ-015 SHALL implement states FILL, DRAIN, DONE; in_ready = (state == FILL).
REQ-016 In FILL, each accepted element SHALL be inserted in one cycle: slot i takes new if a[i-1] <= new < a[i] (i=0: new < a[0]); takes a[i-1] if new < a[i-1]; else keeps a[i].
REQ-017 Equal keys SHALL insert after existing equals (stable).
REQ-018 FILL->DRAIN SHALL occur on the cycle accepting the RUN_LEN-th element or an element with in_last.
REQ-019 A partial run SHALL drain at full RUN_LEN, padding with all-ones.
REQ-020 DRAIN SHALL last RUN_LEN/2 cycles; in DRAIN cycle k, outputs registered next edge: write_en_out=1, even=a[2k], odd=a[2k+1], write_addr_out=run_base+2k.
REQ-021 run_base SHALL start at 0 and advance by RUN_LEN per run; write_addr_out wraps modulo 2^`BANK_ADDR_WIDTH.
REQ-022 After the final drain cycle the array SHALL be refilled with all-ones and runs_out incremented (saturating at 0xFFFF).
REQ-023 Post-drain, state SHALL go to DONE if the run ended with in_last, else to FILL.
REQ-024 In DONE, done_out=1, in_ready=0, write_en_out=0, held until reset.
REQ-025 write_en_out SHALL be 0 in any cycle not following a DRAIN cycle.
REQ-026 in_valid/in_data/in_last SHALL be ignored when in_ready=0.

Reset
REQ-027 Reset SHALL set state FILL, array all-ones, run_base 0, write_addr_out 0, write_en_out 0, even/odd_data_out 0, runs_out 0, done_out 0, sort_err_out 0.
REQ-028 Reset mid-FILL or mid-DRAIN SHALL discard the partial run; no write strobe the cycle after reset.

Configuration
REQ-029 With RUN_SORTER_CHECK_EN defined, sort_err_out SHALL set when a write has even > odd, or even_data_out < previous write's odd_data_out within the same run; sticky until reset.
REQ-030 Without RUN_SORTER_CHECK_EN, sort_err_out SHALL be tied 0 and no check logic synthesised.

Structure
REQ-031 tuple_pair_t, RUN_LEN default and the all-ones sentinel constant SHALL live in the shared aoc5 package, shared with merge_phase.
REQ-032 One sub-module, insert_cell (one slot's compare/shift), SHALL be instantiated RUN_LEN times.

Verification
REQ-033 16 elements 15..0 descending, last on 16th -> 8 writes, addr 0,2..14, pairs (0,1)..(14,15), done_out one cycle after last write.
REQ-034 3 elements 7,2,5 with last -> 8 writes; first pair (2,5), second (7,all-ones), rest all-ones; runs_out=1.
REQ-035 32 elements random, last on 32nd -> addrs 0..30 step 2, each 16-run ascending, runs_out=2, sort_err_out=0.
REQ-036 Duplicates 4,4,1,4 with last -> pairs (1,4),(4,4),then all-ones; in_ready=0 during all 8 drain cycles.
REQ-037 Reset asserted at drain cycle 3 -> no further writes, write_addr_out=0, next run writes from addr 0.
REQ-038 RUN_SORTER_CHECK_EN with forced array corruption -> sort_err_out=1 and stays 1; without macro -> stays 0.
